// File: rtl/gan_pkg.sv
// Shared definitions for the GAN sample sequencer: state encoding, default sample width, wait-timer sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DISC = 2'd2,
        ST_OUT  = 2'd3
    } gan_state_t;

    localparam int GAN_DATA_W  = 16;
    localparam int GAN_LAT_MAX = 15;
    localparam int GAN_TMR_W   = $clog2(16);

    // Reload value for the wait timer. Out-of-range latencies are clamped to 1..15
    // so a bad parameter can never make the timer underflow or wrap.
    function automatic logic [GAN_TMR_W-1:0] lat_load(input int lat);
        int l;
        l = lat;
        if (l < 1) l = 1;
        if (l > GAN_LAT_MAX) l = GAN_LAT_MAX;
        return GAN_TMR_W'(l - 1);
    endfunction

endpackage

// File: rtl/gan_lat_timer.sv
// Load/decrement wait timer shared by the GEN and DISC phases; o_zero marks the last cycle of a phase.
// Latency: load takes effect on the next edge; o_zero is combinational from the count.
// Backpressure: none; holds at zero until reloaded.
module gan_lat_timer
    import gan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [GAN_TMR_W-1:0] i_load_val,
    output logic                 o_zero
);

    logic [GAN_TMR_W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gan_seq_ctrl.sv
// Sequences one noise vector through an external generator then discriminator and holds the result.
// Latency: GEN_LAT+DISC_LAT cycles from input handshake to out_valid; one sample per GEN_LAT+DISC_LAT+1 cycles.
// Backpressure: in_ready low while busy; OUT holds image/prob until out_ready. Optional GAN_SCORE_ACC_EN adds a score accumulator.
module gan_seq_ctrl
    import gan_pkg::*;
#(
    parameter int DATA_W   = GAN_DATA_W,
    parameter int NOISE_N  = 2,
    parameter int IMG_N    = 9,
    parameter int GEN_LAT  = 1,
    parameter int DISC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NOISE_N*DATA_W-1:0] in_noise,
    output logic [NOISE_N*DATA_W-1:0] gen_noise,
    input  logic [IMG_N*DATA_W-1:0]   gen_image,
    output logic [IMG_N*DATA_W-1:0]   disc_image,
    input  logic [DATA_W-1:0]         disc_prob,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IMG_N*DATA_W-1:0]   out_image,
    output logic [DATA_W-1:0]         out_prob,
    output logic                      busy,
    output logic [15:0]               sample_cnt
`ifdef GAN_SCORE_ACC_EN
    ,
    input  logic                      score_clr,
    output logic signed [DATA_W+7:0]  score_sum
`endif
);

    localparam logic [GAN_TMR_W-1:0] GEN_LOAD  = lat_load(GEN_LAT);
    localparam logic [GAN_TMR_W-1:0] DISC_LOAD = lat_load(DISC_LAT);

    gan_state_t                  r_state;
    gan_state_t                  w_next;
    logic [NOISE_N*DATA_W-1:0]   r_noise_q;
    logic [IMG_N*DATA_W-1:0]     r_img_q;
    logic [DATA_W-1:0]           r_prob_q;
    logic [15:0]                 r_sample_cnt;
    logic                        w_tmr_load;
    logic [GAN_TMR_W-1:0]        w_tmr_val;
    logic                        w_tmr_zero;
    logic                        w_in_hs;
    logic                        w_out_hs;

    assign w_in_hs  = in_valid & in_ready;
    assign w_out_hs = out_valid & out_ready;

    // Reload the shared timer whenever a timed phase is entered (including OUT->GEN).
    assign w_tmr_load = ((w_next == ST_GEN)  && (r_state != ST_GEN)) ||
                        ((w_next == ST_DISC) && (r_state != ST_DISC));
    assign w_tmr_val  = (w_next == ST_GEN) ? GEN_LOAD : DISC_LOAD;

    gan_lat_timer u_lat_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: timed phases advance when the timer reads zero, OUT waits for the consumer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)   w_next = ST_GEN;
            ST_GEN:  if (w_tmr_zero) w_next = ST_DISC;
            ST_DISC: if (w_tmr_zero) w_next = ST_OUT;
            ST_OUT:  if (out_ready)  w_next = in_valid ? ST_GEN : ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; in OUT a new sample is taken in the same cycle the result leaves.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin in_ready = 1'b1; busy = 1'b0; end
            ST_OUT:  begin in_ready = out_ready; out_valid = 1'b1; end
            default: ;
        endcase
    end

    // Datapath captures: noise on accept, image on last GEN cycle, probability on last DISC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_noise_q <= '0;
            r_img_q   <= '0;
            r_prob_q  <= '0;
        end else begin
            if (w_in_hs)                             r_noise_q <= in_noise;
            if ((r_state == ST_GEN)  && w_tmr_zero)  r_img_q   <= gen_image;
            if ((r_state == ST_DISC) && w_tmr_zero)  r_prob_q  <= disc_prob;
        end
    end

    // Count completed output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_sample_cnt <= '0;
        else if (w_out_hs) r_sample_cnt <= r_sample_cnt + 16'd1;
    end

    assign gen_noise  = r_noise_q;
    assign disc_image = r_img_q;
    assign out_image  = r_img_q;
    assign out_prob   = r_prob_q;
    assign sample_cnt = r_sample_cnt;

`ifdef GAN_SCORE_ACC_EN
    localparam int SUM_W = DATA_W + 8;

    logic signed [SUM_W-1:0] r_score_sum;
    logic        [SUM_W-1:0] w_prob_ext;
    logic        [SUM_W:0]   w_sum_wide;
    logic        [SUM_W-1:0] w_sum_sat;

    assign w_prob_ext = {{8{r_prob_q[DATA_W-1]}}, r_prob_q};
    assign w_sum_wide = {r_score_sum[SUM_W-1], r_score_sum} + {w_prob_ext[SUM_W-1], w_prob_ext};

    // Saturate when the two top bits of the widened sum disagree (signed overflow).
    always_comb begin
        w_sum_sat = w_sum_wide[SUM_W-1:0];
        if (w_sum_wide[SUM_W] != w_sum_wide[SUM_W-1]) begin
            w_sum_sat = w_sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        end
    end

    // Clear wins over accumulate; a clear coinciding with a handshake restarts from this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_score_sum <= '0;
        else if (score_clr && w_out_hs)  r_score_sum <= w_prob_ext;
        else if (score_clr)              r_score_sum <= '0;
        else if (w_out_hs)               r_score_sum <= w_sum_sat;
    end

    assign score_sum = r_score_sum;
`endif

endmodule

// File: tb/tb_gan_seq_ctrl.sv
// Directed bench for gan_seq_ctrl: a default-latency instance (A) and a GEN_LAT=3/DISC_LAT=2 instance (B).
// External generator/discriminator are modelled as fixed functions of the DUT drive outputs.
// Inputs driven and outputs sampled on the falling edge.
module tb_gan_seq_ctrl;

    localparam int DW = 16;
    localparam int NN = 2;
    localparam int IN = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN*DW-1:0] img_model(input logic [NN*DW-1:0] n);
        logic [IN*DW-1:0] r;
        r = '0;
        for (int k = 0; k < IN; k++) begin
            r[k*DW +: DW] = ((k % 2 == 1) ? n[DW +: DW] : n[0 +: DW]) ^ (16'h0101 * k[15:0]);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] prob_model(input logic [IN*DW-1:0] im);
        return im[0 +: DW] ^ im[(IN-1)*DW +: DW] ^ 16'h5A5A;
    endfunction

    // ---------------- instance A (defaults) ----------------
    logic             a_iv, a_ir, a_ov, a_ordy, a_busy;
    logic [NN*DW-1:0] a_noise, a_gen_noise;
    logic [IN*DW-1:0] a_gen_image, a_disc_image, a_out_image;
    logic [DW-1:0]    a_disc_prob, a_out_prob;
    logic [15:0]      a_cnt;
    logic [DW-1:0]    tgl;
    logic             force_prob;
`ifdef GAN_SCORE_ACC_EN
    logic                    a_clr;
    logic signed [DW+7:0]    a_sum;
    logic                    b_clr;
    logic signed [DW+7:0]    b_sum;
`endif

    assign a_gen_image = img_model(a_gen_noise) ^ {IN{tgl}};
    assign a_disc_prob = force_prob ? 16'h7FFF : (prob_model(a_disc_image) ^ tgl);

    gan_seq_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .in_noise(a_noise),
        .gen_noise(a_gen_noise), .gen_image(a_gen_image),
        .disc_image(a_disc_image), .disc_prob(a_disc_prob),
        .out_valid(a_ov), .out_ready(a_ordy),
        .out_image(a_out_image), .out_prob(a_out_prob),
        .busy(a_busy), .sample_cnt(a_cnt)
`ifdef GAN_SCORE_ACC_EN
        , .score_clr(a_clr), .score_sum(a_sum)
`endif
    );

    // ---------------- instance B (GEN_LAT=3, DISC_LAT=2) ----------------
    logic             b_iv, b_ir, b_ov, b_ordy, b_busy;
    logic [NN*DW-1:0] b_noise, b_gen_noise;
    logic [IN*DW-1:0] b_gen_image, b_disc_image, b_out_image;
    logic [DW-1:0]    b_disc_prob, b_out_prob;
    logic [15:0]      b_cnt;

    assign b_gen_image = img_model(b_gen_noise);
    assign b_disc_prob = prob_model(b_disc_image);

    gan_seq_ctrl #(.GEN_LAT(3), .DISC_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .in_noise(b_noise),
        .gen_noise(b_gen_noise), .gen_image(b_gen_image),
        .disc_image(b_disc_image), .disc_prob(b_disc_prob),
        .out_valid(b_ov), .out_ready(b_ordy),
        .out_image(b_out_image), .out_prob(b_out_prob),
        .busy(b_busy), .sample_cnt(b_cnt)
`ifdef GAN_SCORE_ACC_EN
        , .score_clr(b_clr), .score_sum(b_sum)
`endif
    );

    // Count posedges from the current falling edge until A shows out_valid.
    task automatic a_wait_valid(output int k);
        k = 0;
        while (!a_ov && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int               k, bad, hs, outs, idx, cyc;
        bit               will_acc;
        int               t[4];
        logic [NN*DW-1:0] nz[4];
        logic [NN*DW-1:0] n;
        logic [IN*DW-1:0] exp_img;
        logic [DW-1:0]    exp_prob;

        rst_n = 1'b0;
        a_iv = 1'b0; a_ordy = 1'b1; a_noise = '0;
        b_iv = 1'b0; b_ordy = 1'b1; b_noise = '0;
        tgl = '0; force_prob = 1'b0;
`ifdef GAN_SCORE_ACC_EN
        a_clr = 1'b0; b_clr = 1'b0;
`endif

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  a_ir, 1);
        check_eq("rst_out_valid", a_ov, 0);
        check_eq("rst_busy",      a_busy, 0);
        check_eq("rst_cnt",       a_cnt, 0);
        check_eq("rst_out_image", a_out_image, 0);
        check_eq("rst_out_prob",  a_out_prob, 0);
        check_eq("rst_gen_noise", a_gen_noise, 0);
        rst_n = 1'b1;

        // ---- defaults: noise (0x4000, 0xC000), latency 2 ----
        @(negedge clk);
        n = {16'hC000, 16'h4000};
        a_noise = n; a_iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0;
        check_eq("t1_busy",      a_busy, 1);
        check_eq("t1_in_ready",  a_ir, 0);
        check_eq("t1_gen_noise", a_gen_noise, n);
        a_wait_valid(k);
        check_eq("t1_latency", k, 2);
        exp_img = img_model(n);
        check_eq("t1_out_image", a_out_image, exp_img);
        check_eq("t1_out_prob",  a_out_prob, prob_model(exp_img));
        @(posedge clk);
        @(negedge clk);
        check_eq("t1_cnt",  a_cnt, 1);
        check_eq("t1_idle", a_busy, 0);

        // ---- B: latency 5, in_ready low throughout GEN/DISC ----
        n = {16'h0F0F, 16'h8001};
        b_noise = n; b_iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_iv = 1'b0;
        k = 0; bad = 0;
        while (!b_ov && k < 40) begin
            if (b_ir) bad++;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check_eq("t2_latency",   k, 5);
        check_eq("t2_in_ready0", bad, 0);
        check_eq("t2_out_image", b_out_image, img_model(n));
        check_eq("t2_out_prob",  b_out_prob, prob_model(img_model(n)));
        @(posedge clk);
        @(negedge clk);
        check_eq("t2_cnt", b_cnt, 1);

        // ---- stall: out_ready low 10 cycles, inputs toggling, in_valid ignored ----
        n = {16'h1234, 16'hFEDC};
        a_ordy = 1'b0; a_noise = n; a_iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0;
        a_wait_valid(k);
        check_eq("t3_latency", k, 2);
        exp_img  = img_model(n);
        exp_prob = prob_model(exp_img);
        for (int i = 0; i < 10; i++) begin
            a_iv = 1'b1;
            a_noise = {16'hAAAA, 16'(i)};
            tgl = 16'hFFFF ^ 16'(i);
            @(posedge clk);
            @(negedge clk);
            check_eq("t3_hold_image", a_out_image, exp_img);
            check_eq("t3_hold_prob",  a_out_prob, exp_prob);
        end
        check_eq("t3_gen_noise", a_gen_noise, n);
        check_eq("t3_out_valid", a_ov, 1);
        check_eq("t3_cnt",       a_cnt, 1);
        tgl = '0; a_iv = 1'b0; a_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t3_cnt_after", a_cnt, 2);
        check_eq("t3_idle",      a_busy, 0);

        // ---- 4 back-to-back samples from a fresh reset ----
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nz[0] = {16'h0001, 16'h7FFF};
        nz[1] = {16'h8000, 16'h0002};
        nz[2] = {16'h5555, 16'hAAAA};
        nz[3] = {16'hFFFF, 16'h0000};
        idx = 0; outs = 0; cyc = 0;
        for (int g = 0; g < 60 && outs < 4; g++) begin
            if (g > 0) @(negedge clk);
            if (a_ov && a_ordy) begin
                check_eq("t4_out_image", a_out_image, img_model(nz[outs]));
                outs++;
            end
            if (idx < 4) begin a_iv = 1'b1; a_noise = nz[idx]; end
            else a_iv = 1'b0;
            will_acc = a_iv && a_ir;
            @(posedge clk);
            cyc++;
            if (will_acc) begin t[idx] = cyc; idx++; end
        end
        a_iv = 1'b0;
        check_eq("t4_outs", outs, 4);
        check_eq("t4_gap1", t[1] - t[0], 3);
        check_eq("t4_gap2", t[2] - t[1], 3);
        check_eq("t4_gap3", t[3] - t[2], 3);
        @(negedge clk);
        check_eq("t4_cnt", a_cnt, 4);

        // ---- reset pulsed during DISC ----
        n = {16'h3C3C, 16'hC3C3};
        a_noise = n; a_iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_in_disc", a_busy && !a_ov && !a_ir, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_out_valid", a_ov, 0);
        check_eq("t5_busy",      a_busy, 0);
        check_eq("t5_cnt",       a_cnt, 0);
        check_eq("t5_out_image", a_out_image, 0);
        check_eq("t5_out_prob",  a_out_prob, 0);
        check_eq("t5_gen_noise", a_gen_noise, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_in_ready", a_ir, 1);
        hs = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ov) hs++;
        end
        check_eq("t5_no_output", hs, 0);
        check_eq("t5_cnt_after", a_cnt, 0);

`ifdef GAN_SCORE_ACC_EN
        // ---- score accumulator saturation and clear ----
        force_prob = 1'b1; a_ordy = 1'b1; a_iv = 1'b1;
        for (int g = 0; g < 3000 && a_cnt < 16'd300; g++) begin
            @(posedge clk);
            @(negedge clk);
        end
        a_iv = 1'b0;
        for (int g = 0; g < 20 && a_busy; g++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("acc_cnt_reached", a_cnt >= 16'd300, 1);
        check_eq("acc_sat", a_sum, 24'h7FFFFF);
        a_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_clr = 1'b0;
        check_eq("acc_clr", a_sum, 0);
        force_prob = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gan_seq_ctrl.md
GAN_SEQ_CTRL -- requirements
Module: gan_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sets the Q1.(DATA_W-1) sample width.
REQ-002 Parameter NOISE_N, default 2, sets the number of noise elements per sample.
REQ-003 Parameter IMG_N, default 9, sets the number of image elements per sample.
REQ-004 Parameter GEN_LAT, default 1, sets the generator settle cycles; legal range 1..15.
REQ-005 Parameter DISC_LAT, default 1, sets the discriminator settle cycles; legal range 1..15.
REQ-006 The block SHALL use clock clk and reset rst_n, where rst_n is asynchronous and active-low.
REQ-007 Ports, each as name / direction / width / meaning:
- clk / in / 1 / clock.
- rst_n / in / 1 / async active-low reset.
- in_valid / in / 1 / a noise vector is offered.
- in_ready / out / 1 / the block accepts the noise vector.
- in_noise / in / NOISE_N*DATA_W / packed noise vector; element 0 in the LSBs.
- gen_noise / out / NOISE_N*DATA_W / drive to the external generator.
- gen_image / in / IMG_N*DATA_W / generator result.
- disc_image / out / IMG_N*DATA_W / drive to the external discriminator.
- disc_prob / in / DATA_W / discriminator result.
- out_valid / out / 1 / result held.
- out_ready / in / 1 / consumer takes the result.
- out_image / out / IMG_N*DATA_W / captured image.
- out_prob / out / DATA_W / captured probability.
- busy / out / 1 / state is not IDLE.
- sample_cnt / out / 16 / completed output handshakes.

Function
REQ-008 FSM states SHALL be IDLE, GEN, DISC and OUT, with transitions as follows.
- IDLE to GEN when in_valid is high.
- GEN to DISC after GEN_LAT cycles in GEN.
- DISC to OUT after DISC_LAT cycles in DISC.
- OUT to IDLE on out_ready when in_valid is low.
- OUT to GEN on out_ready when in_valid is high.
REQ-009 in_ready SHALL be 1 in IDLE, equal out_ready in OUT, and be 0 in GEN and DISC.
REQ-010 On an input handshake, in_noise SHALL be registered into noise_q, and gen_noise SHALL equal noise_q at all times.
REQ-011 On the last GEN cycle, gen_image SHALL be captured into img_q, and disc_image SHALL equal img_q at all times.
REQ-012 On the last DISC cycle, disc_prob SHALL be captured into prob_q, and out_valid SHALL rise on the next cycle.
REQ-013 out_valid SHALL be high exactly in OUT, and out_image and out_prob SHALL be held stable until the output handshake.
REQ-014 Latency SHALL be GEN_LAT+DISC_LAT cycles from the input-handshake edge to out_valid high; with defaults this is 2 cycles.
REQ-015 Throughput with back-to-back handshakes SHALL be one sample per GEN_LAT+DISC_LAT+1 cycles.
REQ-016 sample_cnt SHALL increment by 1 per output handshake and wrap from 0xFFFF to 0x0000.
REQ-017 in_valid while busy SHALL be ignored, and the held data and state SHALL be unaffected.
REQ-018 The wait counter SHALL be $clog2(16) bits wide, load LAT-1 on state entry, and leave the state when it reaches 0.
REQ-019 No arithmetic SHALL be applied to datapath values; they pass bit-exact.

Reset
REQ-020 rst_n low SHALL asynchronously force the following values.
- state = IDLE.
- noise_q, img_q, prob_q = 0.
- out_valid = 0, busy = 0, sample_cnt = 0.
- wait counter = 0.
- score_sum = 0 when the score-accumulator feature is present.
REQ-021 A reset mid-sample SHALL discard the sample with no output handshake, and in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-022 When macro GAN_SCORE_ACC_EN is defined, the block SHALL add two ports.
- Input score_clr, 1 bit.
- Output score_sum, DATA_W+8 bits, signed.
REQ-023 With GAN_SCORE_ACC_EN defined, each output handshake SHALL add sign-extended out_prob to score_sum, saturating at the signed min/max.
REQ-024 With GAN_SCORE_ACC_EN defined, score_clr SHALL zero score_sum, and a simultaneous handshake SHALL load score_sum with out_prob.
REQ-025 Without GAN_SCORE_ACC_EN, the ports and accumulator SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package gan_pkg SHALL hold the state encoding (IDLE=0, GEN=1, DISC=2, OUT=3) and the DATA_W default.
REQ-027 Sub-module gan_lat_timer SHALL implement the load/decrement wait counter, with one instance shared by GEN and DISC.

Verification
REQ-028 Defaults, noise (0x4000, 0xC000), out_ready=1 -> out_valid rises 2 cycles after acceptance, and out_image equals the model gen_image.
REQ-029 GEN_LAT=3, DISC_LAT=2 -> out_valid rises 5 cycles after acceptance, and in_ready=0 throughout GEN and DISC.
REQ-030 out_ready held 0 for 10 cycles while gen_image and disc_prob toggle -> out_image and out_prob remain stable, and in_valid is ignored.
REQ-031 4 back-to-back samples with defaults -> samples accepted every 3 cycles, and sample_cnt=4 at the end.
REQ-032 rst_n pulsed during DISC -> all outputs are 0, no output handshake occurs, and in_ready=1 after release.
REQ-033 With GAN_SCORE_ACC_EN: 300 handshakes of prob 0x7FFF -> score_sum saturates at 0x7FFFFF; score_clr -> 0.
